dnn_sequencer: RTL and testbench
================================

DNN_SEQUENCER -- requirements
Module: dnn_sequencer

Interface
REQ-001 SHALL have parameter F_SIZE, default 1024, meaning the weight RAM depth; address F_SIZE-1 is the bias slot.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port len, input, 10, the vector length N (0..F_SIZE-1), sampled at command acceptance.
REQ-005 SHALL have ports start_fwd and start_load, input, 1 each, single-cycle command strobes.
REQ-006 SHALL have ports src_valid (input, 1), src_ready (output, 1) and src_data (input, 16, bfloat16), the activation stream.
REQ-007 SHALL have ports wt_valid (input, 1), wt_ready (output, 1) and wt_data (input, 16, bfloat16), the weight stream.
REQ-008 SHALL have outputs init, exec, bias, update, write and bwrite, 1 each, the core control strobes.
REQ-009 SHALL have outputs ra and wa (10 each), d and wd (16 each), and nrm_en (1, the normalizer enable).
REQ-010 SHALL have outputs busy (1), fwd_done (1, pulse) and load_done (1, pulse).

Function
REQ-011 SHALL implement the states IDLE, LOAD, INIT, RUN, BIAS, DRAIN, UPDATE.
REQ-012 In IDLE, start_load SHALL go to LOAD and start_fwd SHALL go to INIT; if both are asserted, load SHALL win; commands outside IDLE SHALL be ignored.
REQ-013 busy SHALL be 1 in every state other than IDLE.
REQ-014 In LOAD, wt_ready SHALL be 1; each accepted beat k at cycle t SHALL drive write=1, wa=k, wd=wt_data at t+1, for k = 0..N-1.
REQ-015 Beat N SHALL be the bias word: write=1 and bwrite=1 at t+1, then load_done=1 and IDLE at t+2.
REQ-016 INIT SHALL last exactly one cycle with init=1, then go to RUN; init SHALL precede the first exec by at least 1 cycle.
REQ-017 In RUN, src_ready SHALL be 1 while the beat count is below N.
REQ-018 An accepted beat k at cycle t SHALL drive exec=1 and ra=k at t+1, and d=src_data at t+2.
REQ-019 A gap in src_valid SHALL produce a cycle with exec=0; the counter SHALL hold.
REQ-020 After N beats the block SHALL enter BIAS, driving bias=1 for exactly one cycle (cycle b, at least 1 cycle after the last exec), with ra=F_SIZE-1 and d don't-care.
REQ-021 If N=0, the path SHALL be INIT -> BIAS with no exec issued.
REQ-022 DRAIN SHALL last 2 cycles (b+1, b+2) with all strobes 0.
REQ-023 UPDATE SHALL occur at b+3 with update=1 and nrm_en=1 for one cycle.
REQ-024 fwd_done SHALL be 1 at b+4 with the state back in IDLE; a new start is accepted at b+4.
REQ-025 Counters SHALL be 10-bit; N=F_SIZE-1 SHALL not wrap into the bias address during data beats.
REQ-026 At most one of exec, bias, write and update SHALL be asserted per cycle.

Reset
REQ-027 reset SHALL force IDLE and clear counters.
REQ-028 One cycle after reset, all outputs SHALL be 0: strobes, ra, wa, d, wd, src_ready, wt_ready, busy and the done pulses.
REQ-029 Reset mid-RUN or mid-LOAD SHALL abandon the operation with no update or done pulse.
REQ-030 After a reset mid-RUN or mid-LOAD, the next forward pass SHALL re-init the accumulator through INIT.

Structure
REQ-031 Package dnn_ctrl_pkg SHALL hold the state enum plus BIAS_ADDR=F_SIZE-1, BF16_ONE=16'h3f80 and DRAIN_CYC=2.
REQ-032 The block SHALL contain no sub-modules; one beat counter SHALL be shared by LOAD and RUN.
REQ-033 The strobe and address outputs SHALL be registered.
REQ-034 src_ready and wt_ready SHALL be combinational from state and counter.

Verification
REQ-035 Load N=3, wt = 3f80, 4000, 4040, bias 3f80 -> writes wa=0,1,2 then bwrite; load_done 1 cycle after the bias write.
REQ-036 Forward N=3 with src = 3f80 x3 on the core+normalize pair -> nrm=32'h40e00000 (7.0); update at bias+3; fwd_done at bias+4.
REQ-037 Forward N=4 with src_valid low for 2 cycles mid-stream -> exactly 4 exec pulses; ra = 0,1,2,3; result identical to the gapless run.
REQ-038 Forward N=0 -> init, bias, update, fwd_done with no exec; result = bias weight.
REQ-039 start_fwd and start_load in the same cycle -> LOAD entered; a start during busy -> ignored.
REQ-040 reset asserted at RUN beat 2 -> all outputs 0 next cycle; no fwd_done; a following forward gives the correct result.

Source files
------------

// File: rtl/dnn_ctrl_pkg.sv
// Shared types and constants for the DNN layer sequencer.
package dnn_ctrl_pkg;

    localparam int unsigned F_SIZE_DEF = 1024;
    localparam int unsigned CNT_W      = 10;
    localparam logic [CNT_W-1:0] BIAS_ADDR = CNT_W'(F_SIZE_DEF - 1);
    localparam logic [15:0]      BF16_ONE  = 16'h3f80;
    localparam int unsigned      DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StInit,
        StRun,
        StBias,
        StDrain,
        StUpdate
    } state_e;

    // Bias slot is the last word of the weight RAM.
    function automatic logic [CNT_W-1:0] bias_addr_of(int unsigned fsize);
        return CNT_W'(fsize - 1);
    endfunction

endpackage

// File: rtl/dnn_sequencer.sv
// Control sequencer for a single-neuron MAC core: loads weights and runs a
// forward pass (init, N exec beats, bias, drain, update).
import dnn_ctrl_pkg::*;

module dnn_sequencer #(
    parameter int unsigned F_SIZE = F_SIZE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  len,
    input  logic              start_fwd,
    input  logic              start_load,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [15:0]       src_data,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [15:0]       wt_data,
    output logic              init,
    output logic              exec,
    output logic              bias,
    output logic              update,
    output logic              write,
    output logic              bwrite,
    output logic [CNT_W-1:0]  ra,
    output logic [CNT_W-1:0]  wa,
    output logic [15:0]       d,
    output logic [15:0]       wd,
    output logic              nrm_en,
    output logic              busy,
    output logic              fwd_done,
    output logic              load_done
);

    localparam logic [CNT_W-1:0] BiasAddr = bias_addr_of(F_SIZE);
    localparam logic [1:0]       DrainLast = 2'(DRAIN_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             fin_q, fin_d;     // bias word of a load has been taken
    logic [1:0]       drain_q, drain_d;
    logic [15:0]      sdata_q;          // accepted activation, one stage before d

    logic             init_q, init_d;
    logic             exec_q, exec_d;
    logic             bias_q, bias_d;
    logic             update_q, update_d;
    logic             write_q, write_d;
    logic             bwrite_q, bwrite_d;
    logic             nrm_q, nrm_d;
    logic             fdone_q, fdone_d;
    logic             ldone_q, ldone_d;
    logic [CNT_W-1:0] ra_q, ra_d;
    logic [CNT_W-1:0] wa_q, wa_d;
    logic [15:0]      wd_q, wd_d;
    logic [15:0]      d_q;

    logic             src_acc;
    logic             wt_acc;

    // Handshake readiness depends only on state and the shared beat counter.
    always_comb begin
        src_ready = (state_q == StRun) && (cnt_q < len_q);
        wt_ready  = (state_q == StLoad) && !fin_q;
        busy      = (state_q != StIdle);
        src_acc   = src_valid && src_ready;
        wt_acc    = wt_valid && wt_ready;
    end

    // Next-state and registered-strobe decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        fin_d    = fin_q;
        drain_d  = drain_q;
        init_d   = 1'b0;
        exec_d   = 1'b0;
        bias_d   = 1'b0;
        update_d = 1'b0;
        write_d  = 1'b0;
        bwrite_d = 1'b0;
        nrm_d    = 1'b0;
        fdone_d  = 1'b0;
        ldone_d  = 1'b0;
        ra_d     = ra_q;
        wa_d     = wa_q;
        wd_d     = wd_q;

        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                fin_d   = 1'b0;
                drain_d = '0;
                // Load takes priority when both strobes arrive together.
                if (start_load) begin
                    len_d   = len;
                    state_d = StLoad;
                end else if (start_fwd) begin
                    len_d   = len;
                    init_d  = 1'b1;
                    state_d = StInit;
                end
            end
            StLoad: begin
                if (wt_acc) begin
                    write_d = 1'b1;
                    wd_d    = wt_data;
                    if (cnt_q == len_q) begin
                        bwrite_d = 1'b1;
                        wa_d     = BiasAddr;
                        fin_d    = 1'b1;
                    end else begin
                        wa_d  = cnt_q;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (fin_q) begin
                    ldone_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StInit: begin
                if (len_q == '0) begin
                    bias_d  = 1'b1;
                    ra_d    = BiasAddr;
                    state_d = StBias;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Counter stops at N, so N = F_SIZE-1 never reaches the bias slot.
                if (src_acc) begin
                    exec_d = 1'b1;
                    ra_d   = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                end else if (cnt_q == len_q) begin
                    bias_d  = 1'b1;
                    ra_d    = BiasAddr;
                    state_d = StBias;
                end
            end
            StBias: begin
                drain_d = '0;
                state_d = StDrain;
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    update_d = 1'b1;
                    nrm_d    = 1'b1;
                    state_d  = StUpdate;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StUpdate: begin
                fdone_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            len_q    <= '0;
            fin_q    <= 1'b0;
            drain_q  <= '0;
            sdata_q  <= '0;
            init_q   <= 1'b0;
            exec_q   <= 1'b0;
            bias_q   <= 1'b0;
            update_q <= 1'b0;
            write_q  <= 1'b0;
            bwrite_q <= 1'b0;
            nrm_q    <= 1'b0;
            fdone_q  <= 1'b0;
            ldone_q  <= 1'b0;
            ra_q     <= '0;
            wa_q     <= '0;
            wd_q     <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            fin_q    <= fin_d;
            drain_q  <= drain_d;
            init_q   <= init_d;
            exec_q   <= exec_d;
            bias_q   <= bias_d;
            update_q <= update_d;
            write_q  <= write_d;
            bwrite_q <= bwrite_d;
            nrm_q    <= nrm_d;
            fdone_q  <= fdone_d;
            ldone_q  <= ldone_d;
            ra_q     <= ra_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            if (src_acc) begin
                sdata_q <= src_data;
            end
            // Operand follows its exec strobe by one cycle.
            if (exec_q) begin
                d_q <= sdata_q;
            end
        end
    end

    assign init      = init_q;
    assign exec      = exec_q;
    assign bias      = bias_q;
    assign update    = update_q;
    assign write     = write_q;
    assign bwrite    = bwrite_q;
    assign nrm_en    = nrm_q;
    assign fwd_done  = fdone_q;
    assign load_done = ldone_q;
    assign ra        = ra_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign d         = d_q;

endmodule

// File: tb/tb_dnn_sequencer.sv
// Self-checking bench for dnn_sequencer: event-schedule reference model,
// a behavioural MAC core fed by the DUT strobes, directed and random traffic.
module tb_dnn_sequencer;

    localparam int F   = 1024;
    localparam int INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset, start_fwd, start_load, src_valid, wt_valid;
    logic [9:0]  len;
    logic [15:0] src_data, wt_data;
    logic        src_ready, wt_ready, init, exec, bias, update, write, bwrite;
    logic        nrm_en, busy, fwd_done, load_done;
    logic [9:0]  ra, wa;
    logic [15:0] d, wd;

    always #5 clk = ~clk;

    dnn_sequencer #(.F_SIZE(F)) dut (
        .clk(clk), .reset(reset), .len(len),
        .start_fwd(start_fwd), .start_load(start_load),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .init(init), .exec(exec), .bias(bias), .update(update),
        .write(write), .bwrite(bwrite), .ra(ra), .wa(wa), .d(d), .wd(wd),
        .nrm_en(nrm_en), .busy(busy), .fwd_done(fwd_done), .load_done(load_done)
    );

    // Expected events per future cycle, kept in a small ring.
    typedef struct packed {
        logic init, exec, bias, upd, write, bwrite, fdone, ldone, allz, dchk, rchk;
        logic [9:0]  ra, wa;
        logic [15:0] d, wd;
    } exp_t;
    exp_t sch [16];
    real  sch_res [16];

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 0;

    // Reference model: operation mode, length, beat index, timestamps.
    int  m_mode = 0, m_n = 0, m_k = 0, m_open = 0, m_idle_at = 0;
    real m_acc = 0.0;
    logic [15:0] m_w [F];

    // Stimulus controls.
    logic [15:0] wstim [64];
    logic [15:0] sstim [64];
    logic [15:0] tbl [6] = '{16'h3f80, 16'h4000, 16'h4040, 16'h4080, 16'hbf80, 16'h0000};
    bit  nx_rst = 0, nx_sf = 0, nx_sl = 0, rand_valid = 0, spur_en = 0;
    logic [9:0] nx_len = '0;
    int  gap_at = -1, gap_left = 0, rst_at_k = -1;

    // Behavioural MAC core driven by the DUT strobes.
    logic [15:0] core_ram [F];
    real  core_acc = 0.0, core_res = 0.0;
    bit   core_pend = 0;
    logic [9:0] core_pra;
    int   exec_cnt = 0, fdone_cnt = 0, bias_cyc = 0, upd_cyc = 0, fdone_cyc = 0;
    int   bw_cyc = 0, ld_cyc = 0;

    function automatic real bf(logic [15:0] h);
        logic [10:0] e;
        if (h[14:7] == 8'h00) return 0.0;
        e = {3'b000, h[14:7]} + 11'd896;
        return $bitstoreal({h[15], e, h[6:0], 45'b0});
    endfunction

    function automatic logic [31:0] f32(real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic sched_tail(int b);
        sch[b % 16].bias = 1'b1;
        sch[b % 16].ra   = 10'(F - 1);
        sch[(b + 3) % 16].upd  = 1'b1;
        sch[(b + 3) % 16].rchk = 1'b1;
        sch_res[(b + 3) % 16]  = m_acc + bf(m_w[F-1]);
        sch[(b + 4) % 16].fdone = 1'b1;
        m_idle_at = b + 4;
    endtask

    task automatic check_out(int c);
        exp_t e;
        int   s;
        bit   eb, esr, ewr;
        s   = c % 16;
        e   = sch[s];
        eb  = c < m_idle_at;
        esr = (m_mode == 2) && (c >= m_open) && (m_k < m_n) && eb;
        ewr = (m_mode == 1) && (c >= m_open) && (m_k <= m_n) && eb;
        cmp("strobes", {23'b0, init, exec, bias, update, write, bwrite, nrm_en, fwd_done, load_done},
            {23'b0, e.init, e.exec, e.bias, e.upd, e.write, e.bwrite, e.upd, e.fdone, e.ldone});
        cmp("busy_ready", {29'b0, busy, src_ready, wt_ready}, {29'b0, eb, esr, ewr});
        cmp("one_strobe", {31'b0, ($countones({exec, bias, write, update}) <= 1)}, 32'd1);
        if (e.allz) begin
            cmp("ra_wa_zero", {12'b0, ra, wa}, 32'd0);
            cmp("d_wd_zero", {d, wd}, 32'd0);
        end
        if (e.exec || e.bias) cmp("ra", {22'b0, ra}, {22'b0, e.ra});
        if (e.write) begin
            cmp("wa", {22'b0, wa}, {22'b0, e.wa});
            cmp("wd", {16'b0, wd}, {16'b0, e.wd});
        end
        if (e.dchk) cmp("d", {16'b0, d}, {16'b0, e.d});

        if (core_pend) core_acc += bf(core_ram[core_pra]) * bf(d);
        core_pend = 0;
        if (init) core_acc = 0.0;
        if (exec) begin
            core_pend = 1;
            core_pra  = ra;
            exec_cnt++;
        end
        if (bias) begin
            core_acc += bf(core_ram[F-1]);
            bias_cyc = c;
        end
        if (write) core_ram[bwrite ? 10'(F - 1) : wa] = wd;
        if (bwrite) bw_cyc = c;
        if (load_done) ld_cyc = c;
        if (update) begin
            core_res = core_acc;
            upd_cyc  = c;
        end
        if (fwd_done) begin
            fdone_cnt++;
            fdone_cyc = c;
        end
        if (e.rchk) begin
            n_chk++;
            if (core_acc != sch_res[s]) begin
                n_fail++;
                $display("FAIL result cycle %0d: got %f expected %f", c, core_acc, sch_res[s]);
            end
        end
        sch[s] = '0;
    endtask

    task automatic model_step(int c);
        int s1, s2;
        s1 = (c + 1) % 16;
        s2 = (c + 2) % 16;
        if (reset) begin
            for (int i = 0; i < 16; i++) sch[i] = '0;
            sch[s1].allz = 1'b1;
            m_mode    = 0;
            m_idle_at = c + 1;
            return;
        end
        if (c >= m_idle_at) m_mode = 0;
        if (m_mode == 1 && c >= m_open && m_k <= m_n && wt_valid) begin
            sch[s1].write = 1'b1;
            sch[s1].wd    = wt_data;
            if (m_k < m_n) begin
                sch[s1].wa = m_k[9:0];
                m_w[m_k]   = wt_data;
            end else begin
                sch[s1].bwrite = 1'b1;
                sch[s1].wa     = 10'(F - 1);
                m_w[F-1]       = wt_data;
                sch[s2].ldone  = 1'b1;
                m_idle_at      = c + 2;
            end
            m_k++;
        end
        if (m_mode == 2 && c >= m_open && m_k < m_n && src_valid) begin
            sch[s1].exec = 1'b1;
            sch[s1].ra   = m_k[9:0];
            sch[s2].dchk = 1'b1;
            sch[s2].d    = src_data;
            m_acc += bf(m_w[m_k]) * bf(src_data);
            m_k++;
            if (m_k == m_n) sched_tail(c + 2);
        end
        if (c >= m_idle_at) begin
            if (start_load) begin
                m_mode = 1; m_n = int'(len); m_k = 0; m_open = c + 1; m_idle_at = INF;
            end else if (start_fwd) begin
                m_mode = 2; m_n = int'(len); m_k = 0; m_open = c + 2; m_idle_at = INF;
                m_acc  = 0.0;
                sch[s1].init = 1'b1;
                if (len == '0) sched_tail(c + 2);
            end
        end
    endtask

    task automatic cycle();
        bit v;
        int ix;
        @(negedge clk);
        if (chk_en) check_out(cyc);
        chk_en     = 1;
        reset      = nx_rst;
        start_fwd  = nx_sf;
        start_load = nx_sl;
        len        = nx_len;
        if (rst_at_k >= 0 && m_mode != 0 && cyc < m_idle_at && m_k == rst_at_k) begin
            reset    = 1'b1;
            rst_at_k = -1;
        end
        if (spur_en && cyc < m_idle_at && $urandom_range(0, 7) == 0) begin
            start_fwd  = 1'b1;
            start_load = 1'($urandom_range(0, 1));
            len        = 10'($urandom_range(0, 1023));
        end
        v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (gap_left > 0 && m_mode == 2 && m_k == gap_at) begin
            v = 1'b0;
            gap_left--;
        end
        ix        = (m_k < 63) ? m_k : 63;
        src_valid = v;
        wt_valid  = v;
        src_data  = v ? sstim[ix] : 16'($urandom);
        wt_data   = v ? wstim[ix] : 16'($urandom);
        model_step(cyc);
        nx_rst = 0;
        nx_sf  = 0;
        nx_sl  = 0;
        cyc++;
    endtask

    task automatic run_op(bit is_load, int n);
        int i;
        nx_len = 10'(n);
        if (is_load) nx_sl = 1; else nx_sf = 1;
        cycle();
        for (i = 0; i < 3000 && cyc < m_idle_at; i++) cycle();
        if (i >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_timeout cycle %0d: got busy expected idle", cyc);
        end
        cycle();
        cycle();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ec0, fd0, n;
        reset = 1; start_fwd = 0; start_load = 0; len = '0;
        src_valid = 0; wt_valid = 0; src_data = '0; wt_data = '0;
        for (int i = 0; i < F; i++) begin
            m_w[i]      = 16'h0;
            core_ram[i] = 16'h0;
        end
        for (int i = 0; i < 16; i++) begin
            sch[i]     = '0;
            sch_res[i] = 0.0;
        end
        for (int i = 0; i < 64; i++) begin
            wstim[i] = 16'h3f80;
            sstim[i] = 16'h3f80;
        end

        nx_rst = 1; cycle();
        nx_rst = 1; cycle();
        cycle();

        // Both strobes together: load wins; spurious starts while busy.
        wstim[0] = 16'h3f80; wstim[1] = 16'h4000; wstim[2] = 16'h4040; wstim[3] = 16'h3f80;
        spur_en = 1;
        nx_sf = 1;
        run_op(1, 3);
        cmp("ram0", {16'b0, core_ram[0]}, 32'h3f80);
        cmp("ram1", {16'b0, core_ram[1]}, 32'h4000);
        cmp("ram2", {16'b0, core_ram[2]}, 32'h4040);
        cmp("ram_bias", {16'b0, core_ram[F-1]}, 32'h3f80);
        cmp("load_done_lag", ld_cyc - bw_cyc, 32'd1);

        // 1*1 + 2*1 + 3*1 + 1 = 7.0
        run_op(0, 3);
        cmp("nrm_7", f32(core_res), 32'h40e00000);
        cmp("update_lag", upd_cyc - bias_cyc, 32'd3);
        cmp("done_lag", fdone_cyc - bias_cyc, 32'd4);
        spur_en = 0;

        // 2*3 - 1*2 + 3*1 + 1*4 + 4 = 15.0
        wstim[0] = 16'h4000; wstim[1] = 16'hbf80; wstim[2] = 16'h4040;
        wstim[3] = 16'h3f80; wstim[4] = 16'h4080;
        sstim[0] = 16'h4040; sstim[1] = 16'h4000; sstim[2] = 16'h3f80; sstim[3] = 16'h4080;
        run_op(1, 4);
        run_op(0, 4);
        cmp("gapless_15", f32(core_res), 32'h41700000);
        gap_at = 2; gap_left = 2;
        ec0 = exec_cnt;
        run_op(0, 4);
        cmp("gap_exec_cnt", exec_cnt - ec0, 32'd4);
        cmp("gap_15", f32(core_res), 32'h41700000);
        gap_at = -1;

        // N = 0 yields just the bias weight (4.0).
        ec0 = exec_cnt;
        run_op(0, 0);
        cmp("n0_bias", f32(core_res), 32'h40800000);
        cmp("n0_no_exec", exec_cnt - ec0, 32'd0);

        // Reset at beat 2 abandons the pass; the next pass is clean.
        rst_at_k = 2;
        fd0 = fdone_cnt;
        run_op(0, 4);
        cmp("no_done_after_reset", fdone_cnt, fd0);
        rst_at_k = -1;
        run_op(0, 4);
        cmp("after_reset_15", f32(core_res), 32'h41700000);

        // Random mix of loads, passes, gaps, spurious starts and resets.
        rand_valid = 1;
        spur_en    = 1;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 8);
            for (int i = 0; i <= n; i++) begin
                wstim[i] = tbl[$urandom_range(0, 5)];
                sstim[i] = tbl[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 5) == 0) rst_at_k = $urandom_range(0, n);
            if ($urandom_range(0, 4) == 0) nx_sf = 1;
            run_op(($urandom_range(0, 2) == 0), n);
            rst_at_k = -1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
